led_fader: RTL and testbench
============================

# led_fader

Per-channel LED brightness fader that sits directly downstream of the Murax GPIO A output on the iCESugar board. It consumes the low GPIO write bits as on/off targets and drives the board LED pins with glitch-free 8-bit PWM. Each channel ramps its duty cycle one step per fade tick toward full-on or full-off. A bypass mode passes the GPIO bits straight through, registered, for bring-up.

## Interface
- CHANNELS, 8, number of LED channels.
- FADE_DIV, 47000, main-clock cycles per fade tick; must be ≥ 2. A full 0→255 ramp takes 255·FADE_DIV cycles, about 1.0 s at 12 MHz.
- ACTIVE_LOW, 0, 1 inverts every io_led bit, covering lit-when-low LEDs.

Ports:
- io_mainClk  in  1  main clock, single clock domain.
- io_asyncReset_n  in  1  reset, asynchronous assert, active-low.
- io_gpio  in  CHANNELS  target per channel (1 = on), in the io_mainClk domain.
- io_bypass  in  1  1 = io_led follows io_gpio with no fading.
- io_led  out  CHANNELS  LED drive, registered.
- io_settled  out  1  1 when every channel's duty equals its target.

## Operation
- pwm_cnt, 8 bits: increments every cycle and wraps 255→0. One PWM period is 256 cycles.
- fade_pre, ceil(log2(FADE_DIV)) bits:
  - counts 0..FADE_DIV-1, then wraps;
  - fade_tick = 1 for the one cycle where fade_pre == FADE_DIV-1.
- duty[i], 8 bits, updated on fade_tick:
  - io_gpio[i]=1: duty[i] = min(duty[i]+1, 255);
  - io_gpio[i]=0: duty[i] = max(duty[i]-1, 0);
  - saturating; no wrap at 0 or 255.
- shadow[i], 8 bits: loads duty[i] only in the cycle where pwm_cnt == 255. Compare values change only at a period boundary, so there are no partial-period glitches.
  - If fade_tick and pwm_cnt == 255 fall in the same cycle, shadow takes the pre-update duty. The new duty is loaded one period later.
- lit[i] selection:
  - io_bypass=0: lit[i] = (shadow[i] == 255) OR (shadow[i] > pwm_cnt). Duty 0 is never lit; duty 255 is lit continuously.
  - io_bypass=1: lit[i] = io_gpio[i].
- io_bypass does not freeze the fader. Counters, duty and shadow keep running. Clearing bypass resumes from the current shadow with no reset.
- io_led[i] register loads lit[i] XOR ACTIVE_LOW every cycle.
- io_settled register: 1 when, for all i, duty[i] == (io_gpio[i] ? 255 : 0). Computed from the current cycle's duty and io_gpio; registered.

## Timing
- Reset values, while io_asyncReset_n = 0 and immediately on assertion:
  - pwm_cnt, fade_pre, every duty and every shadow = 0;
  - io_led = all ACTIVE_LOW (LEDs dark);
  - io_settled = 1.
- Reset is asynchronous, so assertion mid-ramp or mid-period clears all state on the spot. Deassertion is sampled on a rising io_mainClk edge. The first fade_tick comes FADE_DIV cycles after the first clocked cycle.
- io_led latency: 1 cycle from pwm_cnt/shadow (PWM) or io_gpio (bypass) to the pin.
- From an io_gpio edge:
  - first duty change at the next fade_tick, 1..FADE_DIV cycles later;
  - visible on io_led at the next period boundary, up to 256 further cycles, plus 1.
- io_settled latency: 1 cycle from the duty or io_gpio change that settles or unsettles it.
- A target reversal mid-ramp reverses direction at the next tick from the current duty. No overshoot, no restart.
- A one-cycle io_gpio pulse affects duty only if it coincides with fade_tick.

## Test plan
Directed tests run with FADE_DIV=4, CHANNELS=8, ACTIVE_LOW=0 unless noted.
- Reset: hold io_asyncReset_n=0 with io_gpio=8'hFF.
  - Required: io_led=8'h00 and io_settled=1 throughout.
  - Rerun with ACTIVE_LOW=1: io_led=8'hFF.
- Ramp up: from reset, set io_gpio=8'h01.
  - io_settled drops to 0 within 1 cycle after the first tick.
  - duty[0] reaches 255 after 255 ticks (1020 cycles), then stays there.
  - Once shadow[0]=255, io_led[0] is continuously 1. io_settled returns to 1.
- PWM accuracy: force duty[3]=64 (ramp to it, then hold by toggling the target each tick, or probe the compare).
  - io_led[3] is high exactly 64 of every 256 cycles, contiguous from the cycle after pwm_cnt=0.
- Reversal: ramp channel 2 to duty 100, then clear io_gpio[2].
  - duty[2] goes 100→0 one step per tick, never below 0.
  - io_led[2] is 0 continuously once shadow=0.
- Bypass: mid-ramp, set io_bypass=1 and io_gpio=8'hA5.
  - io_led=8'hA5 one cycle later.
  - Clear bypass: io_led resumes PWM from the current shadow values; duty was not reset.
- Async reset mid-ramp: assert io_asyncReset_n=0 between clock edges at duty=50.
  - io_led clears before the next edge.
  - After release, duty restarts from 0.

Source files
------------

// File: rtl/led_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_fader
// Description : Per-channel LED brightness fader. Each channel's 8-bit duty
//               ramps one step per fade tick toward full-on or full-off. The
//               duty drives a glitch-free 256-cycle PWM through a shadow
//               register that only reloads at the period boundary. A bypass
//               mode routes the GPIO bits straight to the registered pins.
// Revision    : 1.0 - initial release
// ============================================================================
module led_fader #(
    parameter int CHANNELS   = 8,
    parameter int FADE_DIV   = 47000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                io_mainClk,
    input  logic                io_asyncReset_n,
    input  logic [CHANNELS-1:0] io_gpio,
    input  logic                io_bypass,
    output logic [CHANNELS-1:0] io_led,
    output logic                io_settled
);

    // Prescaler width; guarded so a degenerate divider still yields 1 bit.
    localparam int                     c_PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [c_PRE_W-1:0]     c_PRE_LAST = c_PRE_W'(FADE_DIV - 1);
    localparam logic [7:0]             c_DUTY_MAX = 8'hFF;
    localparam logic [7:0]             c_DUTY_MIN = 8'h00;
    localparam logic [CHANNELS-1:0]    c_POLARITY = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [7:0]          r_pwm_cnt;
    logic [c_PRE_W-1:0]  r_fade_pre;
    logic [7:0]          r_duty   [CHANNELS];
    logic [7:0]          r_shadow [CHANNELS];

    logic                w_fade_tick;
    logic                w_pwm_wrap;
    logic [CHANNELS-1:0] w_pwm_lit;
    logic [CHANNELS-1:0] w_at_target;
    logic [CHANNELS-1:0] w_lit;

    assign w_fade_tick = (r_fade_pre == c_PRE_LAST);
    assign w_pwm_wrap  = (r_pwm_cnt == 8'hFF);

    // Free-running PWM phase counter and fade-tick prescaler.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            r_pwm_cnt  <= 8'h00;
            r_fade_pre <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_fade_tick) begin
                r_fade_pre <= '0;
            end else begin
                r_fade_pre <= r_fade_pre + 1'b1;
            end
        end
    end

    // Saturating duty ramp per channel; shadow samples the pre-update duty
    // at the last cycle of each PWM period so compares never change mid-period.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]   <= c_DUTY_MIN;
                r_shadow[i] <= c_DUTY_MIN;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_fade_tick) begin
                    if (io_gpio[i]) begin
                        if (r_duty[i] != c_DUTY_MAX) begin
                            r_duty[i] <= r_duty[i] + 8'd1;
                        end
                    end else if (r_duty[i] != c_DUTY_MIN) begin
                        r_duty[i] <= r_duty[i] - 8'd1;
                    end
                end
                if (w_pwm_wrap) begin
                    r_shadow[i] <= r_duty[i];
                end
            end
        end
    end

    // Per-channel compare and settle detection. Duty 255 is forced fully on
    // because the strict compare alone would leave one dark cycle per period.
    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            assign w_pwm_lit[i]   = (r_shadow[i] == c_DUTY_MAX) || (r_shadow[i] > r_pwm_cnt);
            assign w_at_target[i] = (r_duty[i] == (io_gpio[i] ? c_DUTY_MAX : c_DUTY_MIN));
        end
    endgenerate

    assign w_lit = io_bypass ? io_gpio : w_pwm_lit;

    // Registered pin drive and settled flag; reset leaves LEDs dark and settled.
    always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
        if (!io_asyncReset_n) begin
            io_led     <= c_POLARITY;
            io_settled <= 1'b1;
        end else begin
            io_led     <= w_lit ^ c_POLARITY;
            io_settled <= &w_at_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_fader
// Description : Directed self-checking bench for led_fader with FADE_DIV=4.
//               Edge k counts rising edges after reset release; expected PWM
//               high counts per period are derived by hand from the tick and
//               shadow-load schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_fader;

    logic       clk;
    logic       rst_n;
    logic [7:0] gpio;
    logic       bypass;
    logic [7:0] led;
    logic       settled;
    logic [7:0] led_al;
    logic       settled_al;

    int n_checks;
    int n_fail;
    int k;
    int cnt   [8];
    int first [8];
    int last  [8];
    int al_bad;
    int settle_first;
    int other;

    led_fader #(.CHANNELS(8), .FADE_DIV(4), .ACTIVE_LOW(0)) dut (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .io_gpio         (gpio),
        .io_bypass       (bypass),
        .io_led          (led),
        .io_settled      (settled)
    );

    led_fader #(.CHANNELS(8), .FADE_DIV(4), .ACTIVE_LOW(1)) dut_al (
        .io_mainClk      (clk),
        .io_asyncReset_n (rst_n),
        .io_gpio         (gpio),
        .io_bypass       (bypass),
        .io_led          (led_al),
        .io_settled      (settled_al)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 8; c++) begin
            cnt[c]   = 0;
            first[c] = 0;
            last[c]  = 0;
        end
        al_bad       = 0;
        settle_first = 0;
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
        for (int c = 0; c < 8; c++) begin
            if (led[c]) begin
                cnt[c]++;
                if (first[c] == 0) first[c] = k;
                last[c] = k;
            end
        end
        if (led_al !== ~led || settled_al !== settled) al_bad++;
        if (settled === 1'b1 && settle_first == 0) settle_first = k;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        k        = 0;
        clear_stats();
        rst_n  = 1'b0;
        gpio   = 8'hFF;
        bypass = 1'b0;

        // Reset held with all targets on
        repeat (3) @(posedge clk);
        #1;
        check("rst_led",      led,     8'h00);
        check("rst_led_al",   led_al,  8'hFF);
        check("rst_settled",  settled, 1);

        // Ramp: ch0 and ch2 on from release, release between edges
        gpio = 8'h05;
        #3 rst_n = 1'b1;
        step();
        check("unsettle_e1", settled, 0);
        run(251);                       // k = 252
        gpio = 8'h0D;                   // ch3 joins; first counted tick at 256
        run(4);                         // k = 256

        // Period 1 (edges 257..512); ch2 reverses after edge 400 (duty 100)
        clear_stats();
        run(144);
        gpio = 8'h09;
        run(112);
        other = cnt[1] + cnt[4] + cnt[5] + cnt[6] + cnt[7];
        check("p1_ch0_cnt",   cnt[0],   63);
        check("p1_ch0_first", first[0], 257);
        check("p1_ch0_last",  last[0],  319);
        check("p1_ch2_cnt",   cnt[2],   63);
        check("p1_ch3_cnt",   cnt[3],   0);
        check("p1_other",     other,    0);
        check("p1_al",        al_bad,   0);

        // Period 2 (513..768)
        clear_stats();
        run(256);
        check("p2_ch0_cnt",   cnt[0],   127);
        check("p2_ch2_cnt",   cnt[2],   73);
        check("p2_ch3_cnt",   cnt[3],   64);
        check("p2_ch3_first", first[3], 513);
        check("p2_ch3_last",  last[3],  576);

        // Period 3 (769..1024)
        clear_stats();
        run(256);
        check("p3_ch0_cnt",   cnt[0],   191);
        check("p3_ch2_cnt",   cnt[2],   9);
        check("p3_ch3_cnt",   cnt[3],   128);

        // Period 4 (1025..1280): ch0 saturated on, ch2 floored, ch3 settles at 1273
        clear_stats();
        run(256);
        check("p4_ch0_cnt",   cnt[0],   256);
        check("p4_ch2_cnt",   cnt[2],   0);
        check("p4_ch3_cnt",   cnt[3],   192);
        check("p4_settle_at", settle_first, 1273);
        check("p4_settled",   settled,  1);
        check("p4_al",        al_bad,   0);

        // Bypass: pins follow gpio one edge later, no fade tick in between
        bypass = 1'b1;
        gpio   = 8'hA5;
        step();
        check("byp_led",      led,     8'hA5);
        check("byp_led_al",   led_al,  8'h5A);
        check("byp_settled",  settled, 0);
        gpio = 8'h5A;
        step();
        check("byp_led2",     led,     8'h5A);
        bypass = 1'b0;
        gpio   = 8'h09;
        step();                         // k = 1283, shadows 255 on ch0/ch3
        check("resume_led",   led,     8'h09);
        check("resume_settled", settled, 1);

        // Ramp ch4 to duty 50 (edge 1480), then async reset between edges
        gpio = 8'h19;
        run(197);
        check("pre_arst_led", led, 8'h09);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led",     led,     8'h00);
        check("arst_led_al",  led_al,  8'hFF);
        check("arst_settled", settled, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        k = 0;
        step();
        check("rel_unsettle", settled, 0);
        run(255);                       // k = 256
        clear_stats();
        run(256);                       // period 1 again: duty restarted from 0
        other = cnt[1] + cnt[2] + cnt[5] + cnt[6] + cnt[7];
        check("rel_ch0_cnt",  cnt[0],   63);
        check("rel_ch3_cnt",  cnt[3],   63);
        check("rel_ch4_cnt",  cnt[4],   63);
        check("rel_ch4_first", first[4], 257);
        check("rel_other",    other,    0);
        check("rel_al",       al_bad,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
